// File: rtl/flash_seq.sv
// SPI flash READ (0x03) sequencer: chip-select setup, command + 24-bit address,
// then len received bytes streamed out with a one-clock valid pulse each.
module flash_seq #(
  parameter int LENW    = 8,
  parameter int BYTE_CE = 16,
  parameter int CSH_CE  = 14
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            ce_i,
  input  logic            req_i,
  input  logic [23:0]     addr_i,
  input  logic [LENW-1:0] len_i,
  output logic            busy_o,
  output logic            dv_o,
  output logic [7:0]      dq_o,
  output logic            last_o,
  output logic            fshCs_o,
  output logic            spiTx_o,
  output logic            spiRx_o,
  output logic [7:0]      spiD_o,
  input  logic [7:0]      spiQ_i
);

  // state | meaning
  // IDLE  | waiting for a request, fshCs high
  // CSH   | chip-select high hold before the transaction
  // CMD   | sending the 0x03 opcode
  // A2..A0| sending address bytes, MSB first
  // RD    | len receive phases; byte k-1 is captured at the start of phase k
  // FIN   | capture final byte, then release fshCs
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CSH  = 3'd1;
  localparam logic [2:0] S_CMD  = 3'd2;
  localparam logic [2:0] S_A2   = 3'd3;
  localparam logic [2:0] S_A1   = 3'd4;
  localparam logic [2:0] S_A0   = 3'd5;
  localparam logic [2:0] S_RD   = 3'd6;
  localparam logic [2:0] S_FIN  = 3'd7;

  localparam int PCMAX = (BYTE_CE > CSH_CE) ? BYTE_CE : CSH_CE;
  localparam int PCW   = $clog2(PCMAX + 1);

  logic [2:0]      state_q, state_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic [LENW-1:0] len_q, len_d;
  logic [23:0]     addr_q, addr_d;
  logic            busy_q, busy_d;
  logic            dv_q, dv_d;
  logic            last_q, last_d;
  logic [7:0]      dq_q, dq_d;
  logic            cs_q, cs_d;
  logic            tx_q, tx_d;
  logic            rx_q, rx_d;
  logic [7:0]      spid_q, spid_d;
  logic [7:0]      tx_byte;

  always_comb begin
    tx_byte = 8'h03;
    case (state_q)
      S_A2:    tx_byte = addr_q[23:16];
      S_A1:    tx_byte = addr_q[15:8];
      S_A0:    tx_byte = addr_q[7:0];
      default: tx_byte = 8'h03;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    dv_d    = 1'b0;
    last_d  = 1'b0;
    dq_d    = dq_q;
    cs_d    = cs_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    spid_d  = spid_q;
    if (state_q == S_IDLE) begin
      // Acceptance does not wait for ce
      if (req_i && (len_i != '0)) begin
        addr_d  = addr_i;
        len_d   = len_i;
        busy_d  = 1'b1;
        state_d = S_CSH;
        pc_d    = '0;
        cnt_d   = '0;
      end
    end else if (ce_i) begin
      case (state_q)
        S_CSH: begin
          if (pc_q == PCW'(CSH_CE - 1)) begin
            cs_d    = 1'b0;
            state_d = S_CMD;
            pc_d    = '0;
          end else begin
            pc_d = pc_q + PCW'(1);
          end
        end
        S_CMD, S_A2, S_A1, S_A0: begin
          if (pc_q == '0) begin
            tx_d   = 1'b1;
            spid_d = tx_byte;
          end
          if (pc_q == PCW'(1)) tx_d = 1'b0;
          if (pc_q == PCW'(BYTE_CE - 1)) begin
            pc_d    = '0;
            state_d = state_q + 3'd1;
          end else begin
            pc_d = pc_q + PCW'(1);
          end
        end
        S_RD: begin
          if (pc_q == '0) begin
            rx_d = 1'b1;
            if (cnt_q != '0) begin
              dq_d = spiQ_i;
              dv_d = 1'b1;
            end
          end
          if (pc_q == PCW'(1)) rx_d = 1'b0;
          if (pc_q == PCW'(BYTE_CE - 1)) begin
            pc_d = '0;
            if (cnt_q == len_q - LENW'(1)) state_d = S_FIN;
            else                           cnt_d   = cnt_q + LENW'(1);
          end else begin
            pc_d = pc_q + PCW'(1);
          end
        end
        S_FIN: begin
          if (pc_q == '0) begin
            dq_d   = spiQ_i;
            dv_d   = 1'b1;
            last_d = 1'b1;
            pc_d   = PCW'(1);
          end else begin
            cs_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
            pc_d    = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      dv_q    <= 1'b0;
      last_q  <= 1'b0;
      dq_q    <= '0;
      cs_q    <= 1'b1;
      tx_q    <= 1'b0;
      rx_q    <= 1'b0;
      spid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      dv_q    <= dv_d;
      last_q  <= last_d;
      dq_q    <= dq_d;
      cs_q    <= cs_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      spid_q  <= spid_d;
    end
  end

  assign busy_o  = busy_q;
  assign dv_o    = dv_q;
  assign dq_o    = dq_q;
  assign last_o  = last_q;
  assign fshCs_o = cs_q;
  assign spiTx_o = tx_q;
  assign spiRx_o = rx_q;
  assign spiD_o  = spid_q;

endmodule

// File: tb/tb_flash_seq.sv
// Directed bench for flash_seq: monitors strobes/bytes, models spiQ per rx strobe.
module tb_flash_seq;

  logic        clk = 1'b0;
  logic        reset, ce, req;
  logic [23:0] addr;
  logic [7:0]  len;
  logic        busy_o, dv_o, last_o, fshCs_o, spiTx_o, spiRx_o;
  logic [7:0]  dq_o, spiD_o, spiQ;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flash_seq #(.LENW(8), .BYTE_CE(16), .CSH_CE(14)) dut (
    .clock_i(clk), .reset_i(reset), .ce_i(ce), .req_i(req), .addr_i(addr),
    .len_i(len), .busy_o(busy_o), .dv_o(dv_o), .dq_o(dq_o), .last_o(last_o),
    .fshCs_o(fshCs_o), .spiTx_o(spiTx_o), .spiRx_o(spiRx_o), .spiD_o(spiD_o),
    .spiQ_i(spiQ)
  );

  // ce generation
  int ce_div = 1;
  int ce_cnt = 0;
  bit ce_hold = 0;
  always @(negedge clk) begin
    ce_cnt++;
    ce = !ce_hold && ((ce_cnt % ce_div) == 0);
  end

  function automatic logic [7:0] model(input logic [23:0] a, input int j);
    logic [23:0] s;
    s = a + 24'(j);
    return s[7:0] ^ s[15:8] ^ 8'h3C;
  endfunction

  // monitor
  logic [23:0] cur_addr = '0;
  logic [7:0]  tx_bytes [8];
  logic [7:0]  dv_bytes [256];
  int tx_n, rx_n, dv_n, last_n, last_idx, low_ticks, overlap, dv_consec;
  int busy_falls, orphan_last;
  bit busy_seen, cs_low_seen;
  logic tx_prev = 0, rx_prev = 0, dv_prev = 0, busy_prev = 0;
  logic pre_ce, pre_cs;

  always @(posedge clk) begin
    pre_ce = ce;
    pre_cs = fshCs_o;
    #1;
    if (pre_ce && !pre_cs && !fshCs_o) low_ticks++;
    if (spiTx_o && !tx_prev) begin
      if (tx_n < 8) tx_bytes[tx_n] = spiD_o;
      tx_n++;
    end
    if (spiRx_o && !rx_prev) begin
      spiQ = model(cur_addr, rx_n);
      rx_n++;
    end
    if (spiTx_o && spiRx_o) overlap++;
    if (dv_o) begin
      if (dv_n < 256) dv_bytes[dv_n] = dq_o;
      if (last_o) begin last_n++; last_idx = dv_n; end
      if (dv_prev) dv_consec++;
      dv_n++;
    end
    if (last_o && !dv_o) orphan_last++;
    if (busy_prev && !busy_o) busy_falls++;
    if (busy_o) busy_seen = 1;
    if (!fshCs_o) cs_low_seen = 1;
    tx_prev = spiTx_o; rx_prev = spiRx_o; dv_prev = dv_o; busy_prev = busy_o;
  end

  task automatic clear_mon();
    tx_n = 0; rx_n = 0; dv_n = 0; last_n = 0; last_idx = -1; low_ticks = 0;
    overlap = 0; dv_consec = 0; busy_falls = 0; orphan_last = 0;
    busy_seen = 0; cs_low_seen = 0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy_o && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s timeout: busy=%0b after %0d clocks, expected 0", name, busy_o, n);
    end
  endtask

  task automatic start_req(input logic [23:0] a, input logic [7:0] l);
    @(negedge clk);
    cur_addr = a; addr = a; len = l; req = 1;
    @(negedge clk);
    req = 0;
  endtask

  task automatic check_stream(input string name, input logic [23:0] a, input int l,
                              input int exp_low);
    int bad = 0;
    for (int i = 0; i < l && i < 256; i++) if (dv_bytes[i] !== model(a, i)) bad++;
    checks++;
    if (dv_n !== l) begin errors++; $display("FAIL %s dv_count: got %0d expected %0d", name, dv_n, l); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL %s dq_bytes: %0d wrong bytes, expected 0", name, bad); end
    checks++;
    if (last_n !== 1 || last_idx !== l - 1) begin
      errors++;
      $display("FAIL %s last: count %0d at %0d, expected 1 at %0d", name, last_n, last_idx, l - 1);
    end
    checks++;
    if (low_ticks !== exp_low) begin
      errors++; $display("FAIL %s cs_low_ticks: got %0d expected %0d", name, low_ticks, exp_low);
    end
    checks++;
    if (rx_n !== l) begin errors++; $display("FAIL %s rx_count: got %0d expected %0d", name, rx_n, l); end
    checks++;
    if (overlap !== 0 || dv_consec !== 0 || orphan_last !== 0) begin
      errors++;
      $display("FAIL %s pulses: overlap %0d dv_consec %0d orphan_last %0d, expected 0", name,
               overlap, dv_consec, orphan_last);
    end
  endtask

  task automatic check_cmd(input string name, input logic [23:0] a);
    checks++;
    if (tx_n !== 4 || tx_bytes[0] !== 8'h03 || tx_bytes[1] !== a[23:16] ||
        tx_bytes[2] !== a[15:8] || tx_bytes[3] !== a[7:0]) begin
      errors++;
      $display("FAIL %s tx: n=%0d %h %h %h %h expected 4: 03 %h %h %h", name, tx_n, tx_bytes[0],
               tx_bytes[1], tx_bytes[2], tx_bytes[3], a[23:16], a[15:8], a[7:0]);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({fshCs_o, busy_o, dv_o, last_o, spiTx_o, spiRx_o} !== 6'b100000 ||
        dq_o !== 8'h00 || spiD_o !== 8'h00) begin
      errors++;
      $display("FAIL %s: cs %b busy %b dv %b last %b tx %b rx %b dq %h spiD %h, expected 1 0 0 0 0 0 00 00",
               name, fshCs_o, busy_o, dv_o, last_o, spiTx_o, spiRx_o, dq_o, spiD_o);
    end
  endtask

  task automatic test_reset();
    reset = 0; req = 0; addr = '0; len = '0; spiQ = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    reset = 1;
    @(negedge clk);
  endtask

  task automatic test_basic_read();
    clear_mon();
    ce_div = 8;
    start_req(24'h070000, 8'd4);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL basic accept: busy=%b expected 1", busy_o); end
    wait_idle(20000, "basic");
    check_cmd("basic", 24'h070000);
    check_stream("basic", 24'h070000, 4, 129);
    checks++;
    if (fshCs_o !== 1'b1) begin errors++; $display("FAIL basic cs_end: got %b expected 1", fshCs_o); end
  endtask

  task automatic test_req_held();
    clear_mon();
    ce_div = 2;
    @(negedge clk);
    cur_addr = 24'h123456; addr = 24'h123456; len = 8'd3; req = 1;
    repeat (40) @(negedge clk);
    addr = 24'hABCDEF; len = 8'd9;
    wait_idle(20000, "held");
    req = 0;
    repeat (40) @(negedge clk);
    check_cmd("held", 24'h123456);
    check_stream("held", 24'h123456, 3, 7 * 16 + 1);
    checks++;
    if (busy_falls !== 1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL held busy_falls: got %0d busy %b expected 1 busy 0", busy_falls, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int dv_at;
    clear_mon();
    ce_div = 1;
    start_req(24'h0A0B0C, 8'd8);
    while (dv_n < 2 && n < 5000) begin @(negedge clk); n++; end
    checks++;
    if (dv_n !== 2) begin errors++; $display("FAIL rst_mid reach_rd2: dv_n %0d expected 2", dv_n); end
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    dv_at = dv_n;
    checks++;
    if ({fshCs_o, busy_o, spiTx_o, spiRx_o, dv_o, last_o} !== 6'b100000) begin
      errors++;
      $display("FAIL rst_mid outputs: cs %b busy %b tx %b rx %b dv %b last %b expected 1 0 0 0 0 0",
               fshCs_o, busy_o, spiTx_o, spiRx_o, dv_o, last_o);
    end
    reset = 1;
    repeat (40) @(negedge clk);
    checks++;
    if (dv_n !== dv_at || busy_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid quiet: dv_n %0d busy %b expected %0d 0", dv_n, busy_o, dv_at);
    end
    clear_mon();
    start_req(24'hFFFFFE, 8'd3);
    wait_idle(20000, "rst_mid_new");
    check_cmd("rst_mid_new", 24'hFFFFFE);
    check_stream("rst_mid_new", 24'hFFFFFE, 3, 7 * 16 + 1);
  endtask

  task automatic test_len_zero();
    clear_mon();
    ce_div = 1;
    @(negedge clk);
    addr = 24'h111111; len = 8'd0; req = 1;
    repeat (5) @(negedge clk);
    req = 0;
    repeat (100) @(negedge clk);
    checks++;
    if (busy_seen || cs_low_seen || tx_n != 0 || rx_n != 0 || dv_n != 0) begin
      errors++;
      $display("FAIL len_zero: busy_seen %0b cs_low %0b tx %0d rx %0d dv %0d expected all 0",
               busy_seen, cs_low_seen, tx_n, rx_n, dv_n);
    end
  endtask

  task automatic test_ce_freeze();
    int n = 0;
    int bad = 0;
    int dv_bad = 0;
    logic [7:0] s_d, s_q;
    logic [5:0] s_ctl;
    clear_mon();
    ce_div = 1;
    start_req(24'h3C5A96, 8'd2);
    while (tx_n < 3 && n < 5000) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    ce_hold = 1;
    repeat (2) @(negedge clk);
    s_d = spiD_o; s_q = dq_o;
    s_ctl = {fshCs_o, busy_o, spiTx_o, spiRx_o, last_o, 1'b0};
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if ({fshCs_o, busy_o, spiTx_o, spiRx_o, last_o, 1'b0} !== s_ctl ||
          spiD_o !== s_d || dq_o !== s_q) bad++;
      if (dv_o !== 1'b0) dv_bad++;
    end
    ce_hold = 0;
    checks++;
    if (bad !== 0 || dv_bad !== 0 || s_ctl[5] !== 1'b0) begin
      errors++;
      $display("FAIL ce_freeze: %0d changed, %0d dv, cs %b expected 0 0 0", bad, dv_bad, s_ctl[5]);
    end
    wait_idle(20000, "ce_freeze");
    check_cmd("ce_freeze", 24'h3C5A96);
    check_stream("ce_freeze", 24'h3C5A96, 2, 6 * 16 + 1);
  endtask

  task automatic test_back_to_back();
    clear_mon();
    ce_div = 1;
    @(negedge clk);
    cur_addr = 24'h0000F0; addr = 24'h0000F0; len = 8'd255; req = 1;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b accept1: busy=%b expected 1", busy_o); end
    addr = 24'h200010; len = 8'd2;
    wait_idle(20000, "b2b_first");
    check_stream("b2b_first", 24'h0000F0, 255, 259 * 16 + 1);
    clear_mon();
    cur_addr = 24'h200010;
    @(negedge clk);
    req = 0;
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b accept2: busy=%b expected 1", busy_o); end
    wait_idle(20000, "b2b_second");
    check_cmd("b2b_second", 24'h200010);
    check_stream("b2b_second", 24'h200010, 2, 6 * 16 + 1);
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic_read();
    test_req_held();
    test_reset_mid();
    test_len_zero();
    test_ce_freeze();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
